// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: pipelined fetch memory with fault reporting and a streaming program-load port
module instruction_memory_loadable #(
    parameter int          DEPTH        = 256,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [31:0]                  fetch_addr,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [31:0]                  fetch_instr,
    output logic [1:0]                   fetch_fault,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [31:0]                  load_data,
    input  logic                         load_last,
    output logic                         load_busy,
    output logic [$clog2(DEPTH+1)-1:0]   load_count,
    output logic                         load_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int L  = READ_LATENCY;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t            state_q, state_d;
    logic [L-1:0]      pv_q, pv_d;
    logic [31:0]       pd_q [L];
    logic [31:0]       pd_d [L];
    logic [1:0]        pf_q [L];
    logic [1:0]        pf_d [L];
    logic [CW-1:0]     load_count_q, load_count_d;
    logic              load_overflow_q, load_overflow_d;
    logic [31:0]       mem [DEPTH] = '{default: NOP_WORD};
    logic              accept, entering, full, mem_we;
    logic [1:0]        fault_now;
    logic [31:0]       rdata;

    // State register plus fetch pipeline and load bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RUN;
            pv_q            <= '0;
            pd_q            <= '{default: NOP_WORD};
            pf_q            <= '{default: 2'b00};
            load_count_q    <= '0;
            load_overflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pv_q            <= pv_d;
            pd_q            <= pd_d;
            pf_q            <= pf_d;
            load_count_q    <= load_count_d;
            load_overflow_q <= load_overflow_d;
        end
    end

    // Memory array is never reset so loaded programs survive a reset
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[load_count_q[AW-1:0]] <= load_data;
    end

    // Fetch pipeline: stage 0 captures the fault-resolved read, later stages hold until a new response arrives
    always_comb begin
        accept    = fetch_req && state_q == RUN;
        fault_now = {fetch_addr[31:2] >= 30'(DEPTH), fetch_addr[1:0] != 2'b00};
        rdata     = |fault_now ? NOP_WORD : mem[fetch_addr[AW+1:2]];
        pv_d[0]   = accept;
        pd_d[0]   = accept ? rdata : pd_q[0];
        pf_d[0]   = accept ? fault_now : pf_q[0];
        for (int i = 1; i < L; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
            pf_d[i] = pv_q[i-1] ? pf_q[i-1] : pf_q[i];
        end
    end

    // Load pointer doubles as load_count; it saturates at DEPTH and further words set the overflow flag
    always_comb begin
        entering        = state_q == RUN && load_start;
        full            = load_count_q == CW'(DEPTH);
        mem_we          = !reset && state_q == LOAD && load_valid && !full;
        load_count_d    = entering ? '0 : mem_we ? load_count_q + CW'(1) : load_count_q;
        load_overflow_d = entering ? 1'b0 : (state_q == LOAD && load_valid && full) ? 1'b1 : load_overflow_q;
    end

    // Next state: drain in-flight fetches before accepting load data
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (load_start) state_d = |pv_d ? DRAIN : LOAD;
            DRAIN:   if (!(|pv_d)) state_d = LOAD;
            LOAD:    if (load_valid && load_last) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs
    always_comb begin
        fetch_ready   = state_q == RUN;
        load_busy     = state_q != RUN;
        fetch_valid   = pv_q[L-1];
        fetch_instr   = pd_q[L-1];
        fetch_fault   = pf_q[L-1];
        load_count    = load_count_q;
        load_overflow = load_overflow_q;
    end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: directed checks of fetch timing, faults, drain, load, overflow and reset
module tb_instruction_memory_loadable;
    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready, fetch_valid;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_fault;
    logic        load_start, load_valid, load_last;
    logic [31:0] load_data;
    logic        load_busy;
    logic [4:0]  load_count;
    logic        load_overflow;
    int          vectors = 0;
    int          miscompares = 0;

    instruction_memory_loadable #(.DEPTH(16), .READ_LATENCY(2), .NOP_WORD(32'h00000000)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_busy(load_busy), .load_count(load_count), .load_overflow(load_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        step(); step();
        chk("rst_ready", 32'(fetch_ready), 1);
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_instr", fetch_instr, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 0);
        chk("rst_busy", 32'(load_busy), 0);
        chk("rst_count", 32'(load_count), 0);
        chk("rst_ovf", 32'(load_overflow), 0);
        reset = 1'b0;

        // fetch 0x0 then 0x4 back to back, latency 2
        step(); fetch_req = 1'b1; fetch_addr = 32'h0;
        step(); chk("t1_no_early_valid", 32'(fetch_valid), 0); fetch_addr = 32'h4;
        step(); chk("t1_valid0", 32'(fetch_valid), 1); chk("t1_instr0", fetch_instr, 32'h0);
        chk("t1_fault0", 32'(fetch_fault), 0); fetch_req = 1'b0;
        step(); chk("t1_valid1", 32'(fetch_valid), 1); chk("t1_instr1", fetch_instr, 32'h0);
        step(); chk("t1_idle", 32'(fetch_valid), 0);

        // load three words, then fetch 0x8
        load_start = 1'b1;
        step(); load_start = 1'b0;
        chk("t2_busy", 32'(load_busy), 1); chk("t2_ready", 32'(fetch_ready), 0);
        load_valid = 1'b1; load_data = 32'h01095020;
        step(); load_data = 32'h11090002;
        step(); load_data = 32'h8D090001; load_last = 1'b1;
        step(); load_valid = 1'b0; load_last = 1'b0;
        chk("t2_count", 32'(load_count), 3); chk("t2_busy_fall", 32'(load_busy), 0);
        chk("t2_ready_back", 32'(fetch_ready), 1);
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step(); fetch_req = 1'b0;
        step(); chk("t2_valid", 32'(fetch_valid), 1); chk("t2_instr", fetch_instr, 32'h8D090001);

        // faults: misaligned, out of range, both
        fetch_req = 1'b1; fetch_addr = 32'h6;
        step(); fetch_addr = 32'h40;
        step(); chk("t3_mis_fault", 32'(fetch_fault), 1); chk("t3_mis_instr", fetch_instr, 32'h0);
        chk("t3_mis_valid", 32'(fetch_valid), 1); fetch_addr = 32'h42;
        step(); chk("t3_oor_fault", 32'(fetch_fault), 2); chk("t3_oor_instr", fetch_instr, 32'h0);
        fetch_req = 1'b0;
        step(); chk("t3_both_fault", 32'(fetch_fault), 3); chk("t3_both_instr", fetch_instr, 32'h0);
        step(); chk("t3_hold_valid", 32'(fetch_valid), 0); chk("t3_hold_fault", 32'(fetch_fault), 3);

        // drain: load_start with the second of two fetches; load_valid during DRAIN must be ignored
        fetch_req = 1'b1; fetch_addr = 32'h4;
        step(); chk("t4_ready_pre", 32'(fetch_ready), 1); fetch_addr = 32'h0; load_start = 1'b1;
        step(); fetch_req = 1'b0; load_start = 1'b0;
        chk("t4_ready_drop", 32'(fetch_ready), 0); chk("t4_busy", 32'(load_busy), 1);
        chk("t4_resp0_valid", 32'(fetch_valid), 1); chk("t4_resp0", fetch_instr, 32'h11090002);
        load_valid = 1'b1; load_data = 32'hDEADBEEF;
        step(); chk("t4_resp1_valid", 32'(fetch_valid), 1); chk("t4_resp1", fetch_instr, 32'h01095020);
        step(); chk("t4_drain_ignores_load", 32'(load_count), 0); chk("t4_idle", 32'(fetch_valid), 0);

        // overflow: 18 words into 16 entries, words are 0xA1..0xB2
        for (int i = 1; i <= 18; i++) begin
            load_data = 32'hA0 + 32'(i);
            load_last = (i == 18);
            if (i < 18) step();
        end
        step(); load_valid = 1'b0; load_last = 1'b0;
        chk("t5_count", 32'(load_count), 16); chk("t5_ovf", 32'(load_overflow), 1);
        chk("t5_busy", 32'(load_busy), 0);
        fetch_req = 1'b1; fetch_addr = 32'h3C;
        step(); fetch_req = 1'b0;
        step(); chk("t5_mem15", fetch_instr, 32'hB0); chk("t5_ovf_sticky", 32'(load_overflow), 1);
        load_start = 1'b1;
        step(); load_start = 1'b0;
        chk("t5_ovf_clear", 32'(load_overflow), 0); chk("t5_count_clear", 32'(load_count), 0);

        // reset mid-load after two words
        load_valid = 1'b1; load_data = 32'hC1;
        step(); load_data = 32'hC2;
        step(); load_valid = 1'b0;
        chk("t6_count2", 32'(load_count), 2); reset = 1'b1;
        step(); reset = 1'b0;
        chk("t6_ready", 32'(fetch_ready), 1); chk("t6_busy", 32'(load_busy), 0);
        chk("t6_count", 32'(load_count), 0);
        fetch_req = 1'b1; fetch_addr = 32'h4;
        step(); fetch_addr = 32'h8;
        step(); fetch_req = 1'b0; chk("t6_word1", fetch_instr, 32'hC2);
        step(); chk("t6_word2_old", fetch_instr, 32'hA3);

        // reset with fetches in flight: no response may appear
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step(); fetch_req = 1'b0; reset = 1'b1;
        step(); reset = 1'b0; chk("t7_flush0", 32'(fetch_valid), 0);
        step(); chk("t7_flush1", 32'(fetch_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
